// File: rtl/run_hls_deadlock_pkg.sv
// Shared definitions for the HLS deadlock reporter and the monitor-side logic:
// FSM state encodings and the index-width derivation.
package run_hls_deadlock_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WATCH  = 2'd1,
        REPORT = 2'd2,
        DONE   = 2'd3
    } deadlock_state_t;

    // Width needed to name one of n monitors, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/run_hls_deadlock_prio_enc.sv
// Lowest-set-bit priority encoder. An all-zero input encodes to index 0.
module run_hls_deadlock_prio_enc
    import run_hls_deadlock_pkg::*;
#(
    parameter int NUM_MON = 4,
    localparam int IDX_W  = idx_width(NUM_MON)
) (
    input  logic [NUM_MON-1:0] in_bits,
    output logic [IDX_W-1:0]   idx
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx = '0;
        for (int i = NUM_MON - 1; i >= 0; i--) begin
            if (in_bits[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/run_hls_deadlock_reporter.sv
// Turns per-process HLS block flags into a confirmed, one-shot deadlock
// report. A block must persist for CONFIRM_CYCLES consecutive cycles (any
// monitor may carry the run) before the report is raised on a valid/ready
// handshake, backed by a sticky deadlock flag that only clear or reset drops.
module run_hls_deadlock_reporter
    import run_hls_deadlock_pkg::*;
#(
    parameter int NUM_MON        = 4,
    parameter int CONFIRM_CYCLES = 16,
    parameter int TS_W           = 32,
    localparam int IDX_W         = idx_width(NUM_MON)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_MON-1:0] block_sigs,
    input  logic               clear,
    output logic               report_valid,
    input  logic               report_ready,
    output logic [IDX_W-1:0]   report_idx,
    output logic [NUM_MON-1:0] report_mask,
    output logic [TS_W-1:0]    report_time,
    output logic               deadlock
);

    localparam int CNT_W = $clog2(CONFIRM_CYCLES + 1);
    localparam logic [CNT_W-1:0] CONFIRM_VAL = CNT_W'(CONFIRM_CYCLES);

    deadlock_state_t  state;
    deadlock_state_t  state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] cnt_inc;
    logic [TS_W-1:0]  timestamp;
    logic [TS_W-1:0]  start_time;
    logic [TS_W-1:0]  report_time_nxt;
    logic [IDX_W-1:0] enc_idx;
    logic             any_blk;
    logic             capture_start;
    logic             enter_report;
    logic             transfer;

    assign any_blk = |block_sigs;
    assign cnt_inc = cnt + 1'b1;

    run_hls_deadlock_prio_enc #(
        .NUM_MON (NUM_MON)
    ) u_prio_enc (
        .in_bits (block_sigs),
        .idx     (enc_idx)
    );

    // Free-running timestamp that sticks at all-ones instead of wrapping.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            timestamp <= '0;
        end else if (timestamp != {TS_W{1'b1}}) begin
            timestamp <= timestamp + 1'b1;
        end
    end

    // Next-state and strobe decode; clear overrides every transition.
    always_comb begin
        state_nxt       = state;
        cnt_nxt         = cnt;
        capture_start   = 1'b0;
        enter_report    = 1'b0;
        transfer        = 1'b0;
        report_time_nxt = start_time;
        if (clear) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_blk) begin
                        capture_start = 1'b1;
                        cnt_nxt       = CNT_W'(1);
                        if (CONFIRM_CYCLES == 1) begin
                            state_nxt       = REPORT;
                            enter_report    = 1'b1;
                            report_time_nxt = timestamp;
                        end else begin
                            state_nxt = WATCH;
                        end
                    end
                end
                WATCH: begin
                    if (!any_blk) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt_inc;
                        if (cnt_inc == CONFIRM_VAL) begin
                            state_nxt    = REPORT;
                            enter_report = 1'b1;
                        end
                    end
                end
                REPORT: begin
                    if (report_ready) begin
                        state_nxt = DONE;
                        transfer  = 1'b1;
                    end
                end
                DONE: begin
                    state_nxt = DONE;
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // State, confirm counter and start-of-run timestamp registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            start_time <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (capture_start) begin
                start_time <= timestamp;
            end
        end
    end

    // Report payload, valid and sticky flag: latched on the confirming edge,
    // held through the handshake and afterwards until clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            report_valid <= 1'b0;
            report_idx   <= '0;
            report_mask  <= '0;
            report_time  <= '0;
            deadlock     <= 1'b0;
        end else if (clear) begin
            report_valid <= 1'b0;
            report_idx   <= '0;
            report_mask  <= '0;
            report_time  <= '0;
            deadlock     <= 1'b0;
        end else if (enter_report) begin
            report_valid <= 1'b1;
            report_idx   <= enc_idx;
            report_mask  <= block_sigs;
            report_time  <= report_time_nxt;
            deadlock     <= 1'b1;
        end else if (transfer) begin
            report_valid <= 1'b0;
        end
    end

endmodule
